alu_seq: RTL

Parametrised, registered successor to the combinational 2-bit-opcode ALU in the CPU datapath. It extends the ALU to WIDTH bits and eight operations, adding EOR, logical shifts and an iterative shift-add multiply. Results and NZCV flags are registered, with a start/ready/done handshake. It sits between the register-file read stage and writeback, and is used by the multi-cycle core variant, which stalls while `ready` is low.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq request/response bundle: start/ready handshake, operands,
// opcode and flag enable in; done pulse, result and NZCV flags out.
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [2:0]       ALUControl;
  logic             FlagWrite;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       ALUFlag;

  modport master (
    output start, SrcA, SrcB, ALUControl, FlagWrite,
    input  ready, done, ALUResult, ALUFlag
  );

  modport slave (
    input  start, SrcA, SrcB, ALUControl, FlagWrite,
    output ready, done, ALUResult, ALUFlag
  );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU: single-cycle ADD/SUB/AND/ORR/EOR/LSL/LSR and
// iterative shift-add MUL. Ports: clk, reset (async high), bus (slave).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fw_q, fw_d;
  logic [3:0]       flag_q, flag_d;
  logic             done_q, done_d;

  logic             accept;
  logic             is_mul;
  logic             mul_last;
  logic [WIDTH-1:0] mul_sum;

  logic             is_sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;
  logic [7:0]       amt;
  logic             amt_big;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign accept   = bus.start && (state_q == IDLE);
  assign is_mul   = (bus.ALUControl == 3'b111);
  assign mul_last = (state_q == MUL) && (cnt_q == CW'(WIDTH - 1));
  assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (mul_last)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state_q == IDLE);
  end

  // SUB reuses the adder: A + ~B + 1.
  always_comb begin
    is_sub  = (bus.ALUControl == 3'b001);
    b_x     = is_sub ? ~bus.SrcB : bus.SrcB;
    sum     = {1'b0, bus.SrcA} + {1'b0, b_x}
            + (WIDTH + 1)'(is_sub);
    amt     = bus.SrcB[7:0];
    amt_big = (amt >= 8'(WIDTH));
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (bus.ALUControl)
      3'b000, 3'b001: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.SrcA[WIDTH-1] == b_x[WIDTH-1])
               && (sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      3'b010: alu_res = bus.SrcA & bus.SrcB;
      3'b011: alu_res = bus.SrcA | bus.SrcB;
      3'b100: alu_res = bus.SrcA ^ bus.SrcB;
      3'b101: alu_res = amt_big ? '0 : bus.SrcA << amt;
      3'b110: alu_res = amt_big ? '0 : bus.SrcA >> amt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    fw_d     = fw_q;
    res_d    = res_q;
    flag_d   = flag_q;
    done_d   = 1'b0;
    if (accept) begin
      if (is_mul) begin
        mcand_d  = bus.SrcA;
        mplier_d = bus.SrcB;
        acc_d    = '0;
        cnt_d    = '0;
        fw_d     = bus.FlagWrite;
      end else begin
        res_d  = alu_res;
        done_d = 1'b1;
        if (bus.FlagWrite)
          flag_d = {alu_res[WIDTH-1], alu_res == '0,
                    alu_c, alu_v};
      end
    end else if (state_q == MUL) begin
      acc_d    = mul_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (mul_last) begin
        res_d  = mul_sum;
        done_d = 1'b1;
        if (fw_q)
          flag_d = {mul_sum[WIDTH-1], mul_sum == '0,
                    2'b00};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      fw_q     <= 1'b0;
      res_q    <= '0;
      flag_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      fw_q     <= fw_d;
      res_q    <= res_d;
      flag_q   <= flag_d;
      done_q   <= done_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.ALUResult = res_q;
  assign bus.ALUFlag   = flag_q;
endmodule
